// File: rtl/log_ram_pkg.sv
// Shared types and constants for the log_ram trace buffer: FSM encoding
// and the read/write collision policy selectors.
package log_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/log_ram_if.sv
// Request/response bundle of log_ram: explicit write, append, read port and status.
interface log_ram_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 37
);

  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  push;
  logic                  re;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  wrapped;

  modport master (
    output we, wr_addr, wr_data, push, re, rd_addr,
    input  rd_data, rd_valid, busy, wr_ptr, wrapped
  );

  modport slave (
    input  we, wr_addr, wr_data, push, re, rd_addr,
    output rd_data, rd_valid, busy, wr_ptr, wrapped
  );

endinterface

// File: rtl/log_ram_sdp_ram_core.sv
// Bare simple-dual-port array: one write port, one registered read port
// that returns the contents from before a same-cycle write.
module sdp_ram_core #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 37
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto block RAM; zeroing is done
  // by the owner's sweep through the ordinary write port.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register only: resettable, loads only on a read, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/log_ram.sv
// Logging/trace RAM: explicit writes, wrap-around append pointer, registered
// reads with valid strobe, and a multi-cycle zero-fill clear sweep.
module log_ram
  import log_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 37,
  parameter int BYPASS     = 1
) (
  input  logic     clk,
  input  logic     clr,
  log_ram_if.slave bus
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam bit                    BYP_EN    = (BYPASS == WRITE_FIRST);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_wrapped;
  logic                  r_rd_valid;
  logic                  r_byp_sel;
  logic [DATA_WIDTH-1:0] r_byp_data;

  logic                  w_idle;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_push_en;
  logic                  w_rd_en;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_core_q;

  // clr in the current cycle suppresses all requests; the sweep owns the port in CLEAR.
  assign w_idle = (r_state == IDLE) && !clr;

  // NOTE: every output gets a default before the branches, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_clr_cnt;
    w_wr_data = '0;
    w_push_en = 1'b0;
    if (!clr) begin
      if (r_state == CLEAR) begin
        w_wr_en = 1'b1;
      end else if (bus.we) begin
        w_wr_en   = 1'b1;
        w_wr_addr = bus.wr_addr;
        w_wr_data = bus.wr_data;
      end else if (bus.push) begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_wr_ptr;
        w_wr_data = bus.wr_data;
        w_push_en = 1'b1;
      end
    end
  end

  assign w_rd_en   = w_idle && bus.re;
  assign w_collide = w_wr_en && (w_wr_addr == bus.rd_addr);

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= CLEAR;
      r_clr_cnt  <= '0;
      r_wr_ptr   <= '0;
      r_wrapped  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_byp_sel  <= 1'b0;
      r_byp_data <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_rd_valid <= 1'b0;
          r_clr_cnt  <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_rd_valid <= bus.re;
          if (w_push_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == LAST_ADDR) begin
              r_wrapped <= 1'b1;
            end
          end
          if (w_rd_en) begin
            r_byp_sel  <= BYP_EN && w_collide;
            r_byp_data <= bus.wr_data;
          end
        end
      endcase
    end
  end

  sdp_ram_core #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (clr),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(w_wr_data),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(bus.rd_addr),
    .o_rd_data(w_core_q)
  );

  assign bus.rd_data  = r_byp_sel ? r_byp_data : w_core_q;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = (r_state == CLEAR);
  assign bus.wr_ptr   = r_wr_ptr;
  assign bus.wrapped  = r_wrapped;

endmodule

// File: tb/tb_log_ram.sv
// Bench for log_ram: a write-first and a read-first instance (DEPTH=8) driven
// in lockstep, read results scored against a behavioural model via queues.
module tb_log_ram;

  localparam int AW    = 3;
  localparam int DW    = 37;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  log_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  log_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  log_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1)) dut_a (
    .clk(clk), .clr(clr), .bus(bus_a)
  );

  log_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(0)) dut_b (
    .clk(clk), .clr(clr), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [DW-1:0] m_mem [DEPTH];
  logic [AW-1:0] m_ptr      = '0;
  logic          m_wrapped  = 1'b0;
  int            m_busy_cnt = 0;

  logic [DW-1:0] q_a [$];
  logic [DW-1:0] q_b [$];

  // Read-result monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (bus_a.rd_valid === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL rd_spurious_a: got rd_valid=1 expected no result");
      end else begin
        logic [DW-1:0] e;
        e = q_a.pop_front();
        if (bus_a.rd_data !== e) begin
          errors++;
          $display("FAIL rd_data_a: got %h expected %h", bus_a.rd_data, e);
        end
      end
    end
    if (bus_b.rd_valid === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL rd_spurious_b: got rd_valid=1 expected no result");
      end else begin
        logic [DW-1:0] e;
        e = q_b.pop_front();
        if (bus_b.rd_data !== e) begin
          errors++;
          $display("FAIL rd_data_b: got %h expected %h", bus_b.rd_data, e);
        end
      end
    end
  end

  // One clock cycle of stimulus; updates the model and checks status afterwards.
  task automatic step(input logic c, input logic w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic p, input logic r,
                      input logic [AW-1:0] ra);
    logic          busy_now;
    logic          wr_eff;
    logic [AW-1:0] ea;
    logic          exp_v;
    logic [5:0]    exp_st;
    logic [5:0]    got_a;
    logic [5:0]    got_b;
    clr = c;
    bus_a.we = w; bus_a.wr_addr = wa; bus_a.wr_data = wd;
    bus_a.push = p; bus_a.re = r; bus_a.rd_addr = ra;
    bus_b.we = w; bus_b.wr_addr = wa; bus_b.wr_data = wd;
    bus_b.push = p; bus_b.re = r; bus_b.rd_addr = ra;

    busy_now = (m_busy_cnt != 0);
    exp_v    = r && !c && !busy_now;
    if (!c && !busy_now) begin
      wr_eff = w || p;
      ea     = w ? wa : m_ptr;
      if (r) begin
        q_a.push_back((wr_eff && ea == ra) ? wd : m_mem[ra]);
        q_b.push_back(m_mem[ra]);
      end
      if (wr_eff) m_mem[ea] = wd;
      if (!w && p) begin
        if (m_ptr == AW'(DEPTH - 1)) m_wrapped = 1'b1;
        m_ptr = m_ptr + 1'b1;
      end
    end
    if (c) begin
      m_busy_cnt = DEPTH;
      m_ptr      = '0;
      m_wrapped  = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (busy_now) begin
      m_busy_cnt--;
    end

    @(posedge clk);
    #1;
    exp_st = {m_busy_cnt != 0, exp_v, m_wrapped, m_ptr};
    got_a  = {bus_a.busy, bus_a.rd_valid, bus_a.wrapped, bus_a.wr_ptr};
    got_b  = {bus_b.busy, bus_b.rd_valid, bus_b.wrapped, bus_b.wr_ptr};
    checks++;
    if (got_a !== exp_st) begin
      errors++;
      $display("FAIL status_a {busy,valid,wrapped,ptr}: got %b expected %b", got_a, exp_st);
    end
    checks++;
    if (got_b !== exp_st) begin
      errors++;
      $display("FAIL status_b {busy,valid,wrapped,ptr}: got %b expected %b", got_b, exp_st);
    end
    if (c) begin
      checks++;
      if (bus_a.rd_data !== '0 || bus_b.rd_data !== '0) begin
        errors++;
        $display("FAIL rd_data_after_clr: got %h/%h expected 0", bus_a.rd_data, bus_b.rd_data);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic test_reset();
    int n;
    step(1, 0, '0, '0, 0, 0, '0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_a.busy !== 1'b1) break;
      n++;
      idle(1);
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL reset_busy_cycles: got %0d expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_clear_reads();
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, '0, 0, 1, AW'(i));
    idle(1);
  endtask

  task automatic test_write_read();
    step(0, 1, 3'd5, 37'h1_2345_6789, 0, 0, '0);
    step(0, 0, '0, '0, 0, 1, 3'd5);
    idle(1);
    checks++;
    if (bus_a.rd_data !== 37'h1_2345_6789 || bus_b.rd_data !== 37'h1_2345_6789) begin
      errors++;
      $display("FAIL rd_data_hold: got %h/%h expected %h",
               bus_a.rd_data, bus_b.rd_data, 37'h1_2345_6789);
    end
  endtask

  task automatic test_collision();
    step(0, 1, 3'd2, 37'h55, 0, 0, '0);
    step(0, 1, 3'd2, 37'hAA, 0, 1, 3'd2);
    step(0, 0, '0, '0, 0, 1, 3'd2);
    idle(1);
  endtask

  task automatic test_push_wrap();
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, '0, DW'(i), 1, 0, '0);
      if (i == 8) begin
        checks++;
        if (bus_a.wrapped !== 1'b1 || bus_a.wr_ptr !== 3'd0) begin
          errors++;
          $display("FAIL wrap_after_8: got wrapped=%b ptr=%0d expected wrapped=1 ptr=0",
                   bus_a.wrapped, bus_a.wr_ptr);
        end
      end
    end
    checks++;
    if (bus_a.wr_ptr !== 3'd1 || bus_b.wr_ptr !== 3'd1) begin
      errors++;
      $display("FAIL wr_ptr_after_9: got %0d/%0d expected 1", bus_a.wr_ptr, bus_b.wr_ptr);
    end
    step(0, 0, '0, '0, 0, 1, 3'd0);
    step(0, 0, '0, '0, 0, 1, 3'd7);
    idle(1);
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) step(0, 0, '0, DW'(32'h21 + i), 1, 0, '0);
    step(0, 1, 3'd3, 37'h11, 1, 0, '0);
    checks++;
    if (bus_a.wr_ptr !== 3'd4) begin
      errors++;
      $display("FAIL priority_ptr: got %0d expected 4", bus_a.wr_ptr);
    end
    step(0, 0, '0, '0, 0, 1, 3'd3);
    step(0, 0, '0, '0, 0, 1, 3'd4);
    idle(1);
  endtask

  task automatic test_clr_mid_sweep();
    int n;
    step(1, 0, '0, '0, 0, 0, '0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus_a.busy !== 1'b1) break;
      n++;
      step(i == 3, 1, 3'd6, 37'h1F_0000_00FF, 1, 1, 3'd6);
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL restart_busy_cycles: got %0d expected 12", n);
    end
    checks++;
    if (bus_a.wr_ptr !== 3'd0 || bus_a.wrapped !== 1'b0 ||
        bus_b.wr_ptr !== 3'd0 || bus_b.wrapped !== 1'b0) begin
      errors++;
      $display("FAIL restart_ptr: got ptr=%0d wrapped=%b expected ptr=0 wrapped=0",
               bus_a.wr_ptr, bus_a.wrapped);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, '0, 0, 1, AW'(i));
    idle(1);
  endtask

  initial begin
    bus_a.we = 0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.push = 0; bus_a.re = 0; bus_a.rd_addr = '0;
    bus_b.we = 0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.push = 0; bus_b.re = 0; bus_b.rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    @(posedge clk);
    #1;

    test_reset();
    test_clear_reads();
    test_write_read();
    test_collision();
    test_push_wrap();
    test_priority();
    test_clr_mid_sweep();

    idle(2);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL missing_results: got %0d/%0d outstanding expected 0", q_a.size(), q_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/log_ram.md
Name: log_ram

Overview:
- Parametrised simple-dual-port RAM for hardware-module logging and trace storage.
- One explicit-address write port, plus an append ("push") port with an internal wrap-around write pointer.
- One registered read port with a valid strobe.
- Clear is a deterministic multi-cycle zero-fill sweep, not a single-cycle array reset, so it maps to block RAM.
- Read and write may be active in the same cycle, with a selectable collision policy.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH is derived as 2**ADDR_WIDTH (local, not overridable).
- DATA_WIDTH, 37, word width in bits.
- BYPASS, 1, same-address read/write collision: 1 = write-first (new data), 0 = read-first (old data).

Ports:
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  synchronous active-high reset; also starts the zero-fill sweep
- we  in  1  explicit write strobe
- wr_addr  in  ADDR_WIDTH  explicit write address
- wr_data  in  DATA_WIDTH  write data, shared by we and push
- push  in  1  append write at wr_ptr
- re  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  one-cycle strobe, rd_data updated
- busy  out  1  clear sweep in progress, all requests ignored
- wr_ptr  out  ADDR_WIDTH  next append address
- wrapped  out  1  sticky, set once append has passed DEPTH-1

Behaviour:
- FSM states: IDLE, CLEAR.
- clr=1 at edge N, from any state (including mid-sweep):
  - state<=CLEAR, clr_cnt<=0, wr_ptr<=0, wrapped<=0, rd_valid<=0, rd_data<=0.
  - Mid-sweep clr restarts the count at 0.
- CLEAR:
  - Cycles N+1..N+DEPTH write zero to mem[clr_cnt], then clr_cnt++.
  - After writing DEPTH-1 the FSM goes to IDLE; busy=0 from cycle N+DEPTH+1.
  - busy=1 exactly while in CLEAR.
  - we, push and re are ignored: no write, rd_valid=0, wr_ptr unchanged.
- Power-up contents are undefined. The integrator must assert clr before first use.
- Write (IDLE):
  - we=1: mem[wr_addr]<=wr_data.
  - Else push=1: mem[wr_ptr]<=wr_data and wr_ptr<=wr_ptr+1 (mod DEPTH).
  - If that push writes address DEPTH-1, wrapped<=1 (sticky until clr).
  - we and push together: we wins, push is dropped, wr_ptr unchanged.
- Read (IDLE):
  - re=1 at edge N: rd_data at N+1 = mem[rd_addr], and rd_valid=1 for that single cycle.
  - re=0: rd_valid=0 and rd_data holds its last value (no forced zero).
  - Back-to-back re gives one result per cycle.
- Collision: re with rd_addr equal to the effective write address in the same cycle:
  - BYPASS=1: rd_data=wr_data.
  - BYPASS=0: rd_data = prior contents.
  - The write always commits.
- Reset values: rd_data=0, rd_valid=0, busy=1 (the sweep starts), wr_ptr=0, wrapped=0.
- Widths: wr_ptr and clr_cnt wrap naturally at ADDR_WIDTH bits. clr_cnt compare is against DEPTH-1 at full width.

Decomposition:
- Package log_ram_pkg: FSM state encoding (IDLE=1'b0, CLEAR=1'b1), BYPASS mode constants (READ_FIRST=0, WRITE_FIRST=1).
- Sub-module sdp_ram_core: bare array, one write port, registered read returning old data; no clear logic.
- Top level holds:
  - FSM, clr_cnt, wr_ptr/wrapped.
  - Write-port mux (sweep / we / push).
  - Bypass compare register and rd_valid.

Test Plan:
- ADDR_WIDTH=3, pulse clr one cycle -> busy=1 for exactly 8 cycles; then re addr 0..7 -> rd_data=0, rd_valid=1 each following cycle.
- After clear: we addr 5 data 37'h1_2345_6789; next cycle re addr 5 -> rd_data=37'h1_2345_6789 one cycle later with rd_valid=1; following idle cycle rd_valid=0 and rd_data held.
- Collision: we addr 2 data 'hAA while re addr 2 (old value 'h55) -> BYPASS=1 returns 'hAA, BYPASS=0 returns 'h55; subsequent read gives 'hAA in both builds.
- Push wrap (DEPTH=8): nine pushes data 1..9 -> wr_ptr=1, wrapped=1 after the 8th push; read addr 0 -> 9, addr 7 -> 8.
- Priority: we addr 3 data 'h11 with push data 'h11 at wr_ptr=4 -> mem[3]='h11, mem[4] unchanged, wr_ptr stays 4.
- clr at sweep cycle 4, also with re pending -> rd_valid stays 0, busy stays high a further 8 cycles (total 12), wr_ptr=0, wrapped=0, all entries read 0 afterwards.
